zapper_ctrl: RTL and testbench

// Light-gun front end: conditions raw trigger/detect pins and runs the per-shot flash sequence.

---
 rtl/zapper_if.sv | 23 ++
 rtl/zapper_ctrl.sv | 144 ++++++++++++++
 tb/tb_zapper_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zapper_if.sv
// Pin-level and pattern_gen-facing signals of the light-gun front end.
// The slave side is zapper_ctrl; the master side is whatever drives the pins and frame timing.
interface zapper_if;
  logic trigger;
  logic detect;
  logic frame_start;
  logic valid;
  logic flash_black;
  logic flash_target;
  logic hit;
  logic miss;
  logic busy;

  modport master (
    output trigger, detect, frame_start, valid,
    input  flash_black, flash_target, hit, miss, busy
  );

  modport slave (
    input  trigger, detect, frame_start, valid,
    output flash_black, flash_target, hit, miss, busy
  );
endinterface

// File: rtl/zapper_ctrl.sv
// Light-gun front end: synchronises and debounces the trigger, runs the black/target
// flash sequence on frame boundaries and scores the photodiode response as hit or miss.
module zapper_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BLACK_FRAMES    = 1,
  parameter int unsigned TARGET_FRAMES   = 1,
  parameter int unsigned HIT_THRESH      = 64,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic    clk,
  input  logic    reset,
  zapper_if.slave zif
);
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FMAX_BT = (BLACK_FRAMES > TARGET_FRAMES) ? BLACK_FRAMES : TARGET_FRAMES;
  localparam int unsigned FMAX    = (FMAX_BT > COOLDOWN_FRAMES) ? FMAX_BT : COOLDOWN_FRAMES;
  localparam int unsigned FC_W    = $clog2(FMAX + 1);
  localparam int unsigned HC_W    = (HIT_THRESH > 0) ? $clog2(HIT_THRESH + 1) : 1;

  typedef enum logic [2:0] {IDLE, ARM, BLACK, TARGET, RESULT, COOLDOWN} state_e;

  state_e state, state_d;

  logic            trig_s1, trig_s2, det_s1, det_s2;
  logic [DB_W-1:0] db_cnt;
  logic            trig_db, trig_db_q;
  logic            shot_req;
  logic [FC_W-1:0] fcnt, fcnt_inc;
  logic [HC_W-1:0] hcnt;
  logic            ambient;
  logic            busy_d, flash_black_d, flash_target_d;

  // Two-flop synchronisers for the asynchronous pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      det_s1  <= 1'b0;
      det_s2  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignment so each flop captures its pre-edge input; blocking would collapse the chain into one stage.
      trig_s1 <= zif.trigger;
      trig_s2 <= trig_s1;
      det_s1  <= zif.detect;
      det_s2  <= det_s1;
    end
  end

  // The counter runs only while the synced level disagrees with the accepted one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt    <= '0;
      trig_db   <= 1'b0;
      trig_db_q <= 1'b0;
    end else begin
      trig_db_q <= trig_db;
      if (trig_s2 == trig_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        trig_db <= trig_s2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign shot_req = trig_db & ~trig_db_q;
  assign fcnt_inc = fcnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    unique case (state)
      IDLE:     if (shot_req) state_d = ARM;
      ARM:      if (zif.frame_start) state_d = BLACK;
      BLACK:    if (zif.frame_start && fcnt_inc == FC_W'(BLACK_FRAMES)) state_d = TARGET;
      TARGET:   if (zif.frame_start && fcnt_inc == FC_W'(TARGET_FRAMES)) state_d = RESULT;
      RESULT:   state_d = COOLDOWN;
      COOLDOWN: begin
        if (COOLDOWN_FRAMES == 0 ||
            (zif.frame_start && fcnt_inc == FC_W'(COOLDOWN_FRAMES))) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Frame counter restarts on every stage change; pixel tally and ambient flag cover one shot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt    <= '0;
      hcnt    <= '0;
      ambient <= 1'b0;
    end else begin
      if (state != state_d) begin
        fcnt <= '0;
      end else if (zif.frame_start && (state == BLACK || state == TARGET || state == COOLDOWN)) begin
        fcnt <= fcnt_inc;
      end

      if (state == ARM) begin
        ambient <= 1'b0;
      end else if (state == BLACK && zif.valid && det_s2) begin
        ambient <= 1'b1;
      end

      if (state == BLACK) begin
        hcnt <= '0;
      end else if (state == TARGET && zif.valid && det_s2 && hcnt != '1) begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Flash and busy follow the next state so they update in the cycle after frame_start.
  always_comb begin
    busy_d         = (state_d != IDLE);
    flash_black_d  = (state_d == BLACK);
    flash_target_d = (state_d == TARGET);
    zif.hit        = 1'b0;
    zif.miss       = 1'b0;
    if (state == RESULT) begin
      if (!ambient && hcnt >= HC_W'(HIT_THRESH)) zif.hit  = 1'b1;
      else                                       zif.miss = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zif.busy         <= 1'b0;
      zif.flash_black  <= 1'b0;
      zif.flash_target <= 1'b0;
    end else begin
      zif.busy         <= busy_d;
      zif.flash_black  <= flash_black_d;
      zif.flash_target <= flash_target_d;
    end
  end
endmodule

// File: tb/tb_zapper_ctrl.sv
// Self-checking bench for zapper_ctrl: a shot-level reference model is compared every cycle,
// with directed shots (bounce, hit, miss, threshold edges, ambient, cooldown, reset) and random shots.
module tb_zapper_ctrl;
  localparam int DEB       = 4;
  localparam int BLACKF    = 1;
  localparam int TARGETF   = 1;
  localparam int THRESH    = 8;
  localparam int COOL      = 2;
  localparam int FRAME_LEN = 100;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  zapper_if zif();

  zapper_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BLACK_FRAMES   (BLACKF),
    .TARGET_FRAMES  (TARGETF),
    .HIT_THRESH     (THRESH),
    .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .zif  (zif)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (shot-level phases) ----------------
  typedef enum int {P_IDLE, P_ARM, P_BLACK, P_TARGET, P_RESULT, P_COOL} phase_e;
  phase_e ph = P_IDLE;
  bit [1:0] trig_sh = '0, det_sh = '0;
  bit hist[$];
  bit level = 1'b0, req = 1'b0, amb = 1'b0;
  bit m_trig, m_det, m_req, m_fs, m_vl;
  int frames_left = 0, pixels = 0, disagree;
  bit e_busy = 0, e_fb = 0, e_ft = 0, e_hit = 0, e_miss = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = P_IDLE; trig_sh = '0; det_sh = '0; hist.delete();
      level = 1'b0; req = 1'b0; amb = 1'b0; frames_left = 0; pixels = 0;
    end else begin
      m_trig = trig_sh[1]; m_det = det_sh[1]; m_req = req;
      m_fs = (zif.frame_start === 1'b1); m_vl = (zif.valid === 1'b1);
      trig_sh = {trig_sh[0], zif.trigger === 1'b1};
      det_sh  = {det_sh[0], zif.detect === 1'b1};
      // accepted level flips once the last DEB synced samples all disagree with it
      hist.push_back(m_trig);
      if (hist.size() > DEB) void'(hist.pop_front());
      req = 1'b0;
      if (hist.size() == DEB) begin
        disagree = 0;
        foreach (hist[i]) if (hist[i] != level) disagree++;
        if (disagree == DEB) begin
          req   = !level;
          level = !level;
        end
      end
      case (ph)
        P_IDLE:  if (m_req) ph = P_ARM;
        P_ARM:   if (m_fs) begin ph = P_BLACK; frames_left = BLACKF; amb = 1'b0; end
        P_BLACK: begin
          if (m_vl && m_det) amb = 1'b1;
          if (m_fs) begin
            frames_left--;
            if (frames_left == 0) begin ph = P_TARGET; frames_left = TARGETF; pixels = 0; end
          end
        end
        P_TARGET: begin
          if (m_vl && m_det) pixels++;
          if (m_fs) begin
            frames_left--;
            if (frames_left == 0) ph = P_RESULT;
          end
        end
        P_RESULT: begin ph = P_COOL; frames_left = COOL; end
        P_COOL: begin
          if (frames_left == 0) ph = P_IDLE;
          else if (m_fs) begin
            frames_left--;
            if (frames_left == 0) ph = P_IDLE;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
    e_busy = (ph != P_IDLE);
    e_fb   = (ph == P_BLACK);
    e_ft   = (ph == P_TARGET);
    e_hit  = (ph == P_RESULT) && !amb && (pixels >= THRESH);
    e_miss = (ph == P_RESULT) && !e_hit;
  end

  // ---------------- compare process and observation counters ----------------
  int n_fb = 0, n_ft = 0, n_hit = 0, n_miss = 0, n_busy_rise = 0;
  bit busy_prev = 1'b0;

  always @(negedge clk) begin
    check("busy",         zif.busy,         e_busy);
    check("flash_black",  zif.flash_black,  e_fb);
    check("flash_target", zif.flash_target, e_ft);
    check("hit",          zif.hit,          e_hit);
    check("miss",         zif.miss,         e_miss);
    n_fb   += int'(zif.flash_black === 1'b1);
    n_ft   += int'(zif.flash_target === 1'b1);
    n_hit  += int'(zif.hit === 1'b1);
    n_miss += int'(zif.miss === 1'b1);
    if (zif.busy === 1'b1 && !busy_prev) n_busy_rise++;
    busy_prev = (zif.busy === 1'b1);
  end

  task automatic clear_obs();
    n_fb = 0; n_ft = 0; n_hit = 0; n_miss = 0; n_busy_rise = 0;
  endtask

  // ---------------- frame timing and photodiode driver ----------------
  int fc = 0;
  int det_mode = 0;   // 0 dark, 1 lit during both flash stages, 2 budgeted target pixels, 3 sparse random target
  int det_budget = 0;

  always @(posedge clk) begin
    #1;
    fc = (fc + 1) % FRAME_LEN;
    zif.frame_start = (fc == 0);
    zif.valid       = (fc >= 10 && fc < 90);
    zif.detect      = 1'b0;
    case (det_mode)
      1: zif.detect = e_fb | e_ft;
      2: if (e_ft && zif.valid && det_budget > 0) begin zif.detect = 1'b1; det_budget--; end
      3: zif.detect = e_ft && ($urandom_range(0, 7) == 0);
      default: zif.detect = 1'b0;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    zif.trigger = 1'b1;
    tick(hold);
    zif.trigger = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n = 0;
    while (zif.busy !== val && n < budget) begin tick(1); n++; end
    check(name, zif.busy, val);
  endtask

  task automatic run_shot(input int hold);
    press(hold);
    wait_busy(1'b1, 60, "shot_start");
    wait_busy(1'b0, 800, "shot_end");
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  int bud[4]  = '{20, 5, 8, 7};
  bit want[4] = '{1, 0, 1, 0};

  initial begin
    zif.trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", zif.busy, 0);
    check("rst_flash_black", zif.flash_black, 0);
    check("rst_flash_target", zif.flash_target, 0);
    check("rst_hit", zif.hit, 0);
    check("rst_miss", zif.miss, 0);
    #2 reset = 1'b1;
    tick(5);

    // Bounce then hold: only the clean hold is accepted, and only once.
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      zif.trigger = (i % 2 == 0);
      tick(2);
    end
    zif.trigger = 1'b1;
    n = 0;
    while (zif.busy !== 1'b1 && n < 40) begin tick(1); n++; end
    check("t1_busy_latency", n, 7);
    wait_busy(1'b0, 800, "t1_shot_end");
    tick(50);
    check("t1_single_shot", n_busy_rise, 1);
    check("t1_one_miss", n_miss, 1);
    zif.trigger = 1'b0;
    tick(20);

    // Hit, miss and the threshold edges.
    det_mode = 2;
    for (int i = 0; i < 4; i++) begin
      det_budget = bud[i];
      clear_obs();
      run_shot(10);
      check("tbl_black_cycles", n_fb, FRAME_LEN * BLACKF);
      check("tbl_target_cycles", n_ft, FRAME_LEN * TARGETF);
      check("tbl_hit_pulses", n_hit, want[i] ? 1 : 0);
      check("tbl_miss_pulses", n_miss, want[i] ? 0 : 1);
      tick(20);
    end

    // Ambient light in the black frame forces a miss despite a lit target.
    det_mode = 1;
    clear_obs();
    run_shot(10);
    check("t4_ambient_miss", n_miss, 1);
    check("t4_ambient_no_hit", n_hit, 0);
    tick(20);

    // Cooldown: a press during cooldown is dropped, a later one fires.
    det_mode = 2; det_budget = 20;
    press(10);
    n = 0;
    while (zif.hit !== 1'b1 && n < 700) begin tick(1); n++; end
    check("t5_result_seen", zif.hit, 1);
    clear_obs();
    tick(100);
    press(10);
    n = 110;
    while (zif.busy !== 1'b0 && n < 400) begin tick(1); n++; end
    check("t5_busy_fall_cycles", n, FRAME_LEN * COOL);
    tick(50);
    check("t5_press_dropped", n_busy_rise, 0);
    det_budget = 20;
    clear_obs();
    run_shot(10);
    check("t5_new_shot", n_busy_rise, 1);
    check("t5_new_shot_hit", n_hit, 1);
    tick(20);

    // Mid-shot reset during the target frame.
    det_budget = 20;
    press(10);
    n = 0;
    while (zif.flash_target !== 1'b1 && n < 300) begin tick(1); n++; end
    check("t6_target_reached", zif.flash_target, 1);
    tick(30);
    clear_obs();
    #2 reset = 1'b0;
    #1;
    check("t6_busy_async", zif.busy, 0);
    check("t6_flash_target_async", zif.flash_target, 0);
    check("t6_flash_black_async", zif.flash_black, 0);
    check("t6_hit_async", zif.hit, 0);
    check("t6_miss_async", zif.miss, 0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    det_mode = 0;
    tick(400);
    check("t6_no_result", n_hit + n_miss, 0);
    check("t6_idle_after", zif.busy, 0);
    check("t6_no_restart", n_busy_rise, 0);

    // Random shots with bounce, varied hold and varied photodiode behaviour.
    for (int k = 0; k < 8; k++) begin
      int nb;
      det_mode   = $urandom_range(1, 3);
      det_budget = $urandom_range(0, 20);
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        zif.trigger = 1'b1;
        tick($urandom_range(1, 3));
        zif.trigger = 1'b0;
        tick($urandom_range(1, 3));
      end
      clear_obs();
      run_shot($urandom_range(6, 30));
      check("rnd_one_result", n_hit + n_miss, 1);
      check("rnd_one_shot", n_busy_rise, 1);
      tick($urandom_range(10, 150));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
